// File: rtl/tick_level_gen.sv
// Purpose: gravity/blink tick generator whose period shortens as cleared lines raise the level.
// Latency: all outputs registered; a new level or soft_drop applies at the next counter compare.
// Backpressure: none; pause freezes counter and blink, and line accounting keeps running.
//
// Ports:
//   CLOCK_50     in   system clock
//   resetn       in   asynchronous reset, active low
//   restart      in   synchronous clear, same effect as reset, beats every other input
//   pause        in   hold tick counter and blink, suppress tick_gravity
//   soft_drop    in   use SOFT_PERIOD while held, if it is faster than the level period
//   lines_valid  in   one-cycle pulse: a line clear occurred
//   lines_n      in   lines in that clear (0 ignored, >4 treated as 4)
//   tick_gravity out  one-cycle gravity pulse
//   blink        out  toggles on every tick_gravity
//   level        out  current level, 0..MAX_LEVEL
//   level_up     out  one-cycle pulse when level increments
module tick_level_gen #(
   parameter int CW          = 26,
   parameter int BASE_PERIOD = 24_999_999,
   parameter int STEP        = 5_000_000,
   parameter int MIN_PERIOD  = 4_999_999,
   parameter int SOFT_PERIOD = 2_499_999,
   parameter int LPL         = 10,
   parameter int MAX_LEVEL   = 15,
   parameter int LW          = 4
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic          restart,
   input  logic          pause,
   input  logic          soft_drop,
   input  logic          lines_valid,
   input  logic [2:0]    lines_n,
   output logic          tick_gravity,
   output logic          blink,
   output logic [LW-1:0] level,
   output logic          level_up
);

   // The accumulator never holds more than LPL-1 before an event, and one
   // event adds at most 4, so it must reach LPL+3.
   localparam int AW = $clog2(LPL + 4);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [CW-1:0] count_q,    count_d;
   logic          tick_q,     tick_d;
   logic          blink_q,    blink_d;
   logic [LW-1:0] level_q,    level_d;
   logic          level_up_q, level_up_d;
   logic [AW-1:0] acc_q,      acc_d;

   // ---------------------------------------------------------------------
   // Period selection
   // ---------------------------------------------------------------------
   logic [31:0]   lvl_step;
   logic [CW-1:0] lvl_period;
   logic [CW-1:0] eff_period;

   assign lvl_step = 32'(level_q) * 32'(STEP);

   // Compare before subtracting so the reduction can never underflow.
   always_comb begin
      lvl_period = CW'(MIN_PERIOD);
      if (lvl_step < 32'(BASE_PERIOD - MIN_PERIOD)) begin
         lvl_period = CW'(32'(BASE_PERIOD) - lvl_step);
      end
   end

   // Soft drop only ever speeds the piece up, never slows it down.
   always_comb begin
      eff_period = lvl_period;
      if (soft_drop && (CW'(SOFT_PERIOD) < lvl_period)) begin
         eff_period = CW'(SOFT_PERIOD);
      end
   end

   // ---------------------------------------------------------------------
   // Line accounting helpers
   // ---------------------------------------------------------------------
   logic [2:0]    n_clamp;
   logic [AW-1:0] acc_sum;
   logic          lines_evt;
   logic          at_max;

   assign n_clamp   = (lines_n > 3'd4) ? 3'd4 : lines_n;
   assign acc_sum   = acc_q + AW'(n_clamp);
   assign lines_evt = lines_valid && (n_clamp != 3'd0);
   assign at_max    = (level_q == LW'(MAX_LEVEL));

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      count_d    = count_q;
      tick_d     = 1'b0;
      blink_d    = blink_q;
      level_d    = level_q;
      level_up_d = 1'b0;
      acc_d      = acc_q;

      if (restart) begin
         count_d = '0;
         blink_d = 1'b0;
         level_d = '0;
         acc_d   = '0;
      end else begin
         // Gravity counter. Using >= rather than == means a period that
         // shrinks below the current count fires on the next cycle instead
         // of waiting for the counter to wrap.
         if (!pause) begin
            if (count_q >= eff_period) begin
               count_d = '0;
               tick_d  = 1'b1;
               blink_d = ~blink_q;
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         // Lines keep scoring while paused; LPL >= 4 guarantees a single
         // event can raise the level by at most one.
         if (lines_evt) begin
            if (at_max) begin
               acc_d = '0;
            end else if (acc_sum >= AW'(LPL)) begin
               acc_d      = acc_sum - AW'(LPL);
               level_d    = level_q + 1'b1;
               level_up_d = 1'b1;
            end else begin
               acc_d = acc_sum;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         count_q    <= '0;
         tick_q     <= 1'b0;
         blink_q    <= 1'b0;
         level_q    <= '0;
         level_up_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         count_q    <= count_d;
         tick_q     <= tick_d;
         blink_q    <= blink_d;
         level_q    <= level_d;
         level_up_q <= level_up_d;
         acc_q      <= acc_d;
      end
   end

   assign tick_gravity = tick_q;
   assign blink        = blink_q;
   assign level        = level_q;
   assign level_up     = level_up_q;

endmodule

// File: tb/tb_tick_level_gen.sv
// Purpose: directed bench for tick_level_gen with small periods (BASE=9 STEP=2 MIN=3 SOFT=1 LPL=4).
// Latency: outputs are sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable; inputs are driven right after the sampling point.
module tb_tick_level_gen;

   localparam int CW = 8;
   localparam int LW = 3;

   logic          clk;
   logic          resetn;
   logic          restart;
   logic          pause;
   logic          soft_drop;
   logic          lines_valid;
   logic [2:0]    lines_n;
   logic          tick;
   logic          blink;
   logic [LW-1:0] level;
   logic          level_up;

   int n_vec = 0;
   int n_err = 0;

   tick_level_gen #(
      .CW(CW), .BASE_PERIOD(9), .STEP(2), .MIN_PERIOD(3), .SOFT_PERIOD(1),
      .LPL(4), .MAX_LEVEL(5), .LW(LW)
   ) dut (
      .CLOCK_50     (clk),
      .resetn       (resetn),
      .restart      (restart),
      .pause        (pause),
      .soft_drop    (soft_drop),
      .lines_valid  (lines_valid),
      .lines_n      (lines_n),
      .tick_gravity (tick),
      .blink        (blink),
      .level        (level),
      .level_up     (level_up)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] n;
      int         exp_level;
      int         exp_up;
      int         exp_gap;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of clock edges until tick_gravity is seen high, -1 on timeout.
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (tick !== 1'b1 && cyc < 64);
      if (tick !== 1'b1) cyc = -1;
   endtask

   task automatic do_restart(input string tag);
      restart = 1'b1;
      step();
      restart     = 1'b0;
      lines_valid = 1'b0;
      chk({tag, " tick"},     int'(tick),     0);
      chk({tag, " blink"},    int'(blink),    0);
      chk({tag, " level"},    int'(level),    0);
      chk({tag, " level_up"}, int'(level_up), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int gap;
      int ticks_seen;
      logic blink_hold;

      tbl[0]  = '{3'd4, 1, 1, 8};
      tbl[1]  = '{3'd3, 1, 0, 8};
      tbl[2]  = '{3'd2, 2, 1, 6};
      tbl[3]  = '{3'd2, 2, 0, 6};
      tbl[4]  = '{3'd1, 3, 1, 4};
      tbl[5]  = '{3'd0, 3, 0, 4};
      tbl[6]  = '{3'd7, 4, 1, 4};
      tbl[7]  = '{3'd1, 4, 0, 4};
      tbl[8]  = '{3'd3, 5, 1, 4};
      tbl[9]  = '{3'd4, 5, 0, 4};
      tbl[10] = '{3'd2, 5, 0, 4};

      resetn      = 1'b0;
      restart     = 1'b0;
      pause       = 1'b0;
      soft_drop   = 1'b0;
      lines_valid = 1'b0;
      lines_n     = 3'd0;

      // Reset state
      #1;
      chk("reset tick",     int'(tick),     0);
      chk("reset blink",    int'(blink),    0);
      chk("reset level",    int'(level),    0);
      chk("reset level_up", int'(level_up), 0);
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;

      // Idle at level 0: tick every 10 clocks, blink follows ticks
      wait_tick(gap);
      chk("idle first tick", gap, 10);
      chk("idle blink after tick 1", int'(blink), 1);
      wait_tick(gap);
      chk("idle tick gap", gap, 10);
      chk("idle blink after tick 2", int'(blink), 0);
      chk("idle level", int'(level), 0);

      do_restart("restart0");

      // Line-clear table: level/level_up per event, then tick spacing at that level
      for (int i = 0; i < 11; i++) begin
         lines_valid = 1'b1;
         lines_n     = tbl[i].n;
         step();
         lines_valid = 1'b0;
         chk($sformatf("tbl[%0d] level_up", i), int'(level_up), tbl[i].exp_up);
         chk($sformatf("tbl[%0d] level", i),    int'(level),    tbl[i].exp_level);
         step();
         chk($sformatf("tbl[%0d] level_up drop", i), int'(level_up), 0);
         wait_tick(gap);
         wait_tick(gap);
         chk($sformatf("tbl[%0d] tick gap", i), gap, tbl[i].exp_gap);
      end

      // Restart wins over a simultaneous line clear
      lines_valid = 1'b1;
      lines_n     = 3'd4;
      do_restart("restart+lines");
      step();
      chk("restart+lines level_up next", int'(level_up), 0);
      chk("restart+lines level next",    int'(level),    0);

      // Soft drop asserted at count=6, level 0
      do_restart("restart1");
      repeat (6) step();
      soft_drop = 1'b1;
      step();
      chk("soft immediate tick", int'(tick), 1);
      wait_tick(gap);
      chk("soft gap 1", gap, 2);
      wait_tick(gap);
      chk("soft gap 2", gap, 2);
      soft_drop = 1'b0;
      wait_tick(gap);
      chk("soft release gap", gap, 10);

      // Pause 25 clocks at count=4
      do_restart("restart2");
      repeat (4) step();
      pause      = 1'b1;
      blink_hold = blink;
      ticks_seen = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (tick === 1'b1) ticks_seen++;
      end
      chk("pause ticks", ticks_seen, 0);
      chk("pause blink held", int'(blink), int'(blink_hold));
      pause = 1'b0;
      wait_tick(gap);
      chk("pause resume gap", gap, 6);

      // Lines still count while paused
      pause       = 1'b1;
      lines_valid = 1'b1;
      lines_n     = 3'd4;
      step();
      lines_valid = 1'b0;
      chk("pause lines level_up", int'(level_up), 1);
      chk("pause lines level",    int'(level),    1);
      step();
      chk("pause lines level_up drop", int'(level_up), 0);
      repeat (3) step();
      pause = 1'b0;

      // Async reset mid-count with blink=1 and level=1
      wait_tick(gap);
      if (blink !== 1'b1) wait_tick(gap);
      chk("pre-reset blink", int'(blink), 1);
      repeat (3) step();
      #2;
      resetn = 1'b0;
      #1;
      chk("async reset tick",     int'(tick),     0);
      chk("async reset blink",    int'(blink),    0);
      chk("async reset level",    int'(level),    0);
      chk("async reset level_up", int'(level_up), 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      wait_tick(gap);
      chk("post-reset first tick", gap, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
